// File: rtl/digital_clock_pkg.sv
// Shared types and 50 MHz default timing constants for the digital clock front end.
package digital_clock_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // One channel's conditioned outputs, bundled so the top can slice per lane.
    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic rpt;
    } btn_evt_t;

    localparam int DEF_DEBOUNCE_CYCLES      = 500_000;
    localparam int DEF_REPEAT_DELAY_CYCLES  = 25_000_000;
    localparam int DEF_REPEAT_PERIOD_CYCLES = 5_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One input channel: 2-flop synchronizer, stability-counter debouncer,
// registered press/release edge pulses and the auto-repeat FSM.
module button_channel
    import digital_clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
    parameter bit RPT_EN               = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     raw,
    output btn_evt_t evt
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(max_int(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES) + 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD_CYCLES - 1);

    logic          s1, s2;
    logic          level, press, rel, rpt;
    logic [DW-1:0] db_cnt;
    logic          accept, level_nxt;

    rpt_state_t    state, state_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic          rpt_nxt;

    assign accept    = (s2 != level) && (db_cnt == DB_LAST);
    assign level_nxt = accept ? ~level : level;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            db_cnt <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
            rel    <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == level || accept)
                db_cnt <= '0;
            else
                db_cnt <= db_cnt + 1'b1;
            level <= level_nxt;
            press <= accept & ~level;
            rel   <= accept & level;
        end
    end

    // The FSM looks at the next debounced level so a release wins over a
    // timer expiry landing on the same edge, and the press-time repeat pulse
    // lines up with btn_press.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        rpt_nxt   = 1'b0;
        if (!level_nxt) begin
            state_nxt = RPT_IDLE;
            tmr_nxt   = '0;
        end else begin
            case (state)
                RPT_IDLE: begin
                    tmr_nxt = '0;
                    if (accept) begin
                        rpt_nxt = 1'b1;
                        if (RPT_EN)
                            state_nxt = RPT_DELAY;
                    end
                end
                RPT_DELAY: begin
                    if (tmr == DLY_LAST) begin
                        rpt_nxt   = 1'b1;
                        tmr_nxt   = '0;
                        state_nxt = RPT_REPEAT;
                    end else begin
                        tmr_nxt = tmr + 1'b1;
                    end
                end
                RPT_REPEAT: begin
                    if (tmr == PER_LAST) begin
                        rpt_nxt = 1'b1;
                        tmr_nxt = '0;
                    end else begin
                        tmr_nxt = tmr + 1'b1;
                    end
                end
                default: begin
                    state_nxt = RPT_IDLE;
                    tmr_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RPT_IDLE;
            tmr   <= '0;
            rpt   <= 1'b0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            rpt   <= rpt_nxt;
        end
    end

    assign evt = '{level, press, rel, rpt};

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: NUM_BTN independent button_channel lanes
// feeding the clock core's button/switch inputs.
module button_conditioner
    import digital_clock_pkg::*;
#(
    parameter int                 NUM_BTN              = 3,
    parameter int                 DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
    parameter int                 REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
    parameter int                 REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
    parameter logic [NUM_BTN-1:0] REPEAT_EN            = '1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    btn_evt_t [NUM_BTN-1:0] evt;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
            .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES),
            .RPT_EN              (REPEAT_EN[i])
        ) u_ch (
            .clk(clk),
            .rst(rst),
            .raw(btn_raw[i]),
            .evt(evt[i])
        );

        assign btn_level[i]   = evt[i].level;
        assign btn_press[i]   = evt[i].press;
        assign btn_release[i] = evt[i].rel;
        assign btn_repeat[i]  = evt[i].rpt;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timing.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn_raw;
    logic [2:0] btn_level, btn_press, btn_release, btn_repeat;

    int cyc, total, bad, k, p;
    int press_n[3], press_last[3], rel_n[3], rel_last[3], rep_n[3], hi_n[3];
    int rep_t[3][16];

    button_conditioner #(
        .NUM_BTN             (3),
        .DEBOUNCE_CYCLES     (4),
        .REPEAT_DELAY_CYCLES (20),
        .REPEAT_PERIOD_CYCLES(8),
        .REPEAT_EN           (3'b101)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 3; i++) begin
            press_n[i] = 0; press_last[i] = -1;
            rel_n[i] = 0;   rel_last[i] = -1;
            rep_n[i] = 0;   hi_n[i] = 0;
            for (int j = 0; j < 16; j++) rep_t[i][j] = -1;
        end
    endtask

    // Advance one edge, then log every output event with the edge number.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (btn_press[i]) begin press_n[i]++; press_last[i] = cyc; end
            if (btn_release[i]) begin rel_n[i]++; rel_last[i] = cyc; end
            if (btn_repeat[i]) begin
                if (rep_n[i] < 16) rep_t[i][rep_n[i]] = cyc;
                rep_n[i]++;
            end
            if (btn_level[i]) hi_n[i]++;
        end
    endtask

    initial begin
        int exp_rep[5];
        cyc = 0; total = 0; bad = 0;
        rst = 1'b1;
        btn_raw = 3'b000;
        clr();
        tick();
        tick();
        chk("rst_level", btn_level, 0);
        chk("rst_press", btn_press, 0);
        chk("rst_release", btn_release, 0);
        chk("rst_repeat", btn_repeat, 0);
        rst = 1'b0;
        repeat (3) tick();

        // Clean press on ch0, held 50 samples.
        clr();
        btn_raw[0] = 1'b1;
        k = cyc + 1; p = k + 5;
        while (cyc < k + 49) tick();
        chk("clean_level_hi", btn_level[0], 1);
        btn_raw[0] = 1'b0;
        while (cyc < k + 64) tick();
        chk("clean_press_n", press_n[0], 1);
        chk("clean_press_cyc", press_last[0], p);
        chk("clean_rep_n", rep_n[0], 5);
        exp_rep = '{0, 20, 28, 36, 44};
        for (int j = 0; j < 5; j++)
            chk($sformatf("clean_rep%0d_cyc", j), rep_t[0][j], p + exp_rep[j]);
        chk("clean_rel_n", rel_n[0], 1);
        chk("clean_rel_cyc", rel_last[0], k + 55);
        chk("clean_level_lo", btn_level[0], 0);
        chk("clean_other_ch", press_n[1] + press_n[2] + rep_n[1] + rep_n[2], 0);

        // Bounce: 2-cycle toggles for 20 cycles, then stable high.
        clr();
        for (int i = 0; i < 10; i++) begin
            btn_raw[0] = (i % 2 == 0);
            tick();
            tick();
        end
        chk("bounce_quiet", press_n[0] + hi_n[0] + rel_n[0], 0);
        btn_raw[0] = 1'b1;
        k = cyc + 1;
        while (cyc < k + 14) tick();
        chk("bounce_press_n", press_n[0], 1);
        chk("bounce_press_cyc", press_last[0], k + 5);
        btn_raw[0] = 1'b0;
        repeat (12) tick();
        chk("bounce_rel_n", rel_n[0], 1);

        // Glitch: 3-sample high pulse on ch2 never reaches the output.
        clr();
        btn_raw[2] = 1'b1;
        repeat (3) tick();
        btn_raw[2] = 1'b0;
        repeat (12) tick();
        chk("glitch_level", hi_n[2], 0);
        chk("glitch_events", press_n[2] + rel_n[2] + rep_n[2], 0);

        // All channels pressed together; ch1 has repeat disabled; ch0 released
        // so its fall lands on a repeat-expiry edge.
        clr();
        btn_raw = 3'b111;
        k = cyc + 1; p = k + 5;
        while (cyc < k + 59) begin
            tick();
            if (cyc == k + 27) btn_raw[0] = 1'b0;
        end
        btn_raw = 3'b000;
        while (cyc < k + 75) tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sim_press%0d_n", i), press_n[i], 1);
            chk($sformatf("sim_press%0d_cyc", i), press_last[i], p);
        end
        chk("sim_ch0_rep_n", rep_n[0], 2);
        chk("sim_ch0_rep1_cyc", rep_t[0][1], p + 20);
        chk("sim_ch0_rel_cyc", rel_last[0], p + 28);
        chk("sim_ch1_rep_n", rep_n[1], 1);
        chk("sim_ch1_rep0_cyc", rep_t[1][0], p);
        chk("sim_ch1_rel_cyc", rel_last[1], k + 65);
        chk("sim_ch2_rep_n", rep_n[2], 6);
        chk("sim_ch2_rep5_cyc", rep_t[2][5], p + 52);
        chk("sim_ch2_rel_cyc", rel_last[2], k + 65);

        // Reset while ch0 sits in the repeat phase with raw still high.
        clr();
        btn_raw[0] = 1'b1;
        k = cyc + 1; p = k + 5;
        while (cyc < p + 25) tick();
        chk("rsthold_rep_n", rep_n[0], 2);
        rst = 1'b1;
        tick();
        chk("rsthold_level", btn_level, 0);
        chk("rsthold_events", {btn_press, btn_release, btn_repeat}, 0);
        rst = 1'b0;
        clr();
        while (cyc < p + 41) tick();
        chk("rsthold_press_n", press_n[0], 1);
        chk("rsthold_press_cyc", press_last[0], p + 32);
        chk("rsthold_rep0_cyc", rep_t[0][0], p + 32);
        chk("rsthold_rel_n", rel_n[0], 0);
        btn_raw = 3'b000;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end input conditioner for the digital clock's push-buttons and switch. Synchronizes asynchronous board inputs to `clk`, debounces them with a per-channel stability counter, and emits single-cycle press and release pulses. It also emits an auto-repeat pulse train while a button is held. Its outputs drive the clock core's `button_C`, `button_M` and `SW_0` inputs directly (press/repeat pulse or level as chosen per channel at the top level).

## Interface
- `NUM_BTN`, 3: number of independent input channels.
- `DEBOUNCE_CYCLES`, 500_000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz). Must be ≥1.
- `REPEAT_DELAY_CYCLES`, 25_000_000: hold time from the press pulse to the first auto-repeat pulse (500 ms). Must be ≥1.
- `REPEAT_PERIOD_CYCLES`, 5_000_000: spacing between subsequent auto-repeat pulses (100 ms). Must be ≥1.
- `REPEAT_EN`, all ones: per-channel mask; a 0 bit disables auto-repeat on that channel.

Ports:
- `clk`  in  1: system clock, 50 MHz.
- `rst`  in  1: synchronous, active-high reset.
- `btn_raw`  in  NUM_BTN: raw asynchronous inputs, active-high.
- `btn_level`  out  NUM_BTN: debounced level.
- `btn_press`  out  NUM_BTN: one-cycle pulse on accepted 0→1 transition.
- `btn_release`  out  NUM_BTN: one-cycle pulse on accepted 1→0 transition.
- `btn_repeat`  out  NUM_BTN: press pulse plus auto-repeat pulses, one cycle each.

## Operation
- Each channel is fully independent. Simultaneous activity on several channels is processed in parallel with identical timing.
- Synchronizer: two flip-flops, `s1` then `s2`, reset to 0.
- Debounce:
  - While `s2 == btn_level`, the counter is held at 0.
  - While they differ, the counter increments each cycle.
  - On the cycle the counter equals DEBOUNCE_CYCLES-1 and `s2` still differs, `btn_level` toggles and the counter clears.
  - Any return of `s2` to `btn_level` before that point clears the counter. Glitches shorter than DEBOUNCE_CYCLES produce no output.
- Edge pulses:
  - `btn_press` is asserted in the same cycle `btn_level` first reads 1.
  - `btn_release` is asserted in the same cycle `btn_level` first reads 0.
  - Each lasts exactly one cycle.
- Repeat FSM, per channel, states RPT_IDLE, RPT_DELAY, RPT_REPEAT:
  - RPT_IDLE: on a press pulse, assert `btn_repeat` and go to RPT_DELAY (only if `REPEAT_EN` bit = 1; otherwise stay in RPT_IDLE and still pass the press pulse to `btn_repeat`). The timer loads 0.
  - RPT_DELAY: the timer counts. When it reaches REPEAT_DELAY_CYCLES-1 with `btn_level`=1, pulse `btn_repeat`, clear the timer and go to RPT_REPEAT.
  - RPT_REPEAT: when the timer reaches REPEAT_PERIOD_CYCLES-1, pulse `btn_repeat` and clear the timer.
  - From any state, `btn_level`=0 returns the channel to RPT_IDLE immediately with no pulse. Release has priority over a coincident timer expiry.
- Counter widths are $clog2(param+1). Counters never wrap: they are cleared at terminal count.

## Timing
- Raw change first sampled at edge k → `btn_level` and `btn_press`/`btn_release` are visible after edge k+1+DEBOUNCE_CYCLES.
- Auto-repeat pulses:
  - The first auto-repeat pulse occurs exactly REPEAT_DELAY_CYCLES cycles after the press pulse.
  - Later pulses follow every REPEAT_PERIOD_CYCLES cycles.
- All outputs are registered; there is no combinational path from `btn_raw`.
- Reset:
  - While `rst`=1, all outputs, synchronizers, counters and FSMs reset to 0/RPT_IDLE, with effect at the next edge.
  - A reset mid-hold or mid-debounce discards state.
  - A button still held after reset deasserts is re-accepted as a new press after the full debounce latency.

## Structure
- Shared package `digital_clock_pkg`:
  - `rpt_state_t` enum (RPT_IDLE, RPT_DELAY, RPT_REPEAT).
  - Default-cycle constants for the 50 MHz build.
- Sub-module `button_channel`: one channel's synchronizer, debouncer, edge detector and repeat FSM. The top level instantiates NUM_BTN copies in a generate loop.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_PERIOD_CYCLES=8, NUM_BTN=3.
- Clean press: raw 0→1 held 50 cycles → `btn_level`=1 and a single `btn_press` at edge k+5; `btn_repeat` pulses at press+0, +20, +28, +36, +44; release → one `btn_release` 5 edges later, no further repeats.
- Bounce: raw toggles every 2 cycles for 20 cycles, then stays 1 → no output during bounce; exactly one press, 5 edges after final stable sample.
- Glitch: 3-cycle high pulse on raw → all outputs remain 0.
- REPEAT_EN=3'b101, channel 1 held 60 cycles → `btn_repeat`[1] pulses only once, at the press; channels 0/2 unaffected.
- Simultaneous: all three channels pressed on the same edge → identical press cycles; release of ch0 on a repeat-expiry cycle → no pulse on ch0.
- Reset mid-hold: `rst` for 1 cycle while ch0 is in RPT_REPEAT with raw still 1 → outputs 0 the next cycle; new press accepted 5 edges after reset deasserts.
